// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared inverter definitions: leg FSM encoding, leg order and gate bit map.
package pwm_deadtime_gen_pkg;

  typedef enum logic [1:0] {
    LEG_DEAD  = 2'b00,
    LEG_LO_ON = 2'b01,
    LEG_HI_ON = 2'b10
  } leg_state_e;

  localparam int unsigned NUM_LEGS = 4;

  // Leg order inside the command vector
  localparam int unsigned LEG_H1A = 0;
  localparam int unsigned LEG_H1B = 1;
  localparam int unsigned LEG_H2A = 2;
  localparam int unsigned LEG_H2B = 3;

  // Gate bit positions: each leg occupies {hi, lo}
  localparam int unsigned GATE_H1A_LO = 0;
  localparam int unsigned GATE_H1A_HI = 1;
  localparam int unsigned GATE_H1B_LO = 2;
  localparam int unsigned GATE_H1B_HI = 3;
  localparam int unsigned GATE_H2A_LO = 4;
  localparam int unsigned GATE_H2A_HI = 5;
  localparam int unsigned GATE_H2B_LO = 6;
  localparam int unsigned GATE_H2B_HI = 7;

endpackage

// File: rtl/pwm_deadtime_gen_leg.sv
// One half-bridge leg: break-before-make switching with a programmable dead time.
module deadtime_leg
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cmd,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                hi,
  output logic                lo
);

  leg_state_e          state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DT_WIDTH-1:0] dt_min1;

  // A zero dead time still yields a one-cycle both-off gap
  assign dt_min1 = (deadtime == '0) ? DT_WIDTH'(1) : deadtime;

  // State and dead counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEG_DEAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: leave the active side on command change, pick the side only at expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = LEG_DEAD;
      cnt_d   = dt_min1;
    end else begin
      unique case (state_q)
        LEG_HI_ON: begin
          if (!cmd) begin
            state_d = LEG_DEAD;
            cnt_d   = dt_min1;
          end
        end
        LEG_LO_ON: begin
          if (cmd) begin
            state_d = LEG_DEAD;
            cnt_d   = dt_min1;
          end
        end
        default: begin
          // Counter 0 (only after reset) and 1 both expire on this edge
          if (cnt_q <= DT_WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = cmd ? LEG_HI_ON : LEG_LO_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign hi = (state_q == LEG_HI_ON);
  assign lo = (state_q == LEG_LO_ON);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Two H-bridge PWM modulator: shadowed reference, level-shifted carrier compare, four dead-time legs.
module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int unsigned CARRIER_WIDTH = 16,
  parameter int unsigned DT_WIDTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic signed [CARRIER_WIDTH-1:0] ref_in,
  input  logic signed [CARRIER_WIDTH-1:0] carrier1,
  input  logic signed [CARRIER_WIDTH-1:0] carrier2,
  input  logic                            sync_pulse,
  input  logic        [DT_WIDTH-1:0]      deadtime,
  output logic        [7:0]               gate
);

  localparam logic signed [CARRIER_WIDTH-1:0] S_MIN = {1'b1, {(CARRIER_WIDTH-1){1'b0}}};
  localparam logic signed [CARRIER_WIDTH-1:0] S_MAX = {1'b0, {(CARRIER_WIDTH-1){1'b1}}};

  logic signed [CARRIER_WIDTH-1:0] ref_sh_q, ref_sh_d;
  logic signed [CARRIER_WIDTH-1:0] neg_ref;
  logic        [NUM_LEGS-1:0]      cmd_q, cmd_d;
  logic        [NUM_LEGS-1:0]      leg_hi, leg_lo;

  // Shadow reference: reloaded at carrier peak, tracks the input while disabled
  always_comb begin
    ref_sh_d = ref_sh_q;
    if (sync_pulse || !enable) begin
      ref_sh_d = ref_in;
    end
  end

  // Negating the most negative value saturates instead of wrapping
  assign neg_ref = (ref_sh_q == S_MIN) ? S_MAX : -ref_sh_q;

  // Signed strict compares against the lower and upper carriers
  always_comb begin
    cmd_d          = '0;
    cmd_d[LEG_H1A] = (ref_sh_q > carrier1);
    cmd_d[LEG_H1B] = (neg_ref  > carrier1);
    cmd_d[LEG_H2A] = (ref_sh_q > carrier2);
    cmd_d[LEG_H2B] = (neg_ref  > carrier2);
  end

  // Reference shadow and leg command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sh_q <= '0;
      cmd_q    <= '0;
    end else begin
      ref_sh_q <= ref_sh_d;
      cmd_q    <= cmd_d;
    end
  end

  for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
    deadtime_leg #(
      .DT_WIDTH (DT_WIDTH)
    ) u_leg (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .cmd      (cmd_q[i]),
      .deadtime (deadtime),
      .hi       (leg_hi[i]),
      .lo       (leg_lo[i])
    );
  end

  assign gate[GATE_H1A_LO] = leg_lo[LEG_H1A];
  assign gate[GATE_H1A_HI] = leg_hi[LEG_H1A];
  assign gate[GATE_H1B_LO] = leg_lo[LEG_H1B];
  assign gate[GATE_H1B_HI] = leg_hi[LEG_H1B];
  assign gate[GATE_H2A_LO] = leg_lo[LEG_H2A];
  assign gate[GATE_H2A_HI] = leg_hi[LEG_H2A];
  assign gate[GATE_H2B_LO] = leg_lo[LEG_H2B];
  assign gate[GATE_H2B_HI] = leg_hi[LEG_H2B];

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: directed stimulus queues timed expectations, a negedge monitor checks them.
module tb_pwm_deadtime_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic signed [15:0] ref_in;
  logic signed [15:0] carrier1;
  logic signed [15:0] carrier2;
  logic               sync_pulse;
  logic        [7:0]  deadtime;
  logic        [7:0]  gate;

  typedef struct {
    int unsigned when;
    int          kind;   // 0: gate value, 1: gate change count, 2: H2A hi-cycle count
    logic [7:0]  val;
    logic [7:0]  mask;
    int unsigned base;
    int          lo;
    int          hi;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc        = 0;
  int unsigned n_cmp      = 0;
  int unsigned n_err      = 0;
  int unsigned chg_cnt    = 0;
  int unsigned h2a_hi_cnt = 0;
  logic [7:0]  gate_prev  = 8'h00;
  logic        done       = 1'b0;

  pwm_deadtime_gen #(
    .CARRIER_WIDTH (16),
    .DT_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .ref_in     (ref_in),
    .carrier1   (carrier1),
    .carrier2   (carrier2),
    .sync_pulse (sync_pulse),
    .deadtime   (deadtime),
    .gate       (gate)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-cycle overlap check, activity counters, scoreboard pops
  always @(negedge clk) begin
    n_cmp++;
    assert ((gate & (gate >> 1) & 8'h55) == 8'h00)
    else begin
      n_err++;
      $display("FAIL hi_lo_overlap: cycle %0d gate=%h, required no leg with hi and lo both on", cyc, gate);
    end
    if (gate !== gate_prev) chg_cnt++;
    gate_prev = gate;
    if (gate[5]) h2a_hi_cnt++;

    while (sb_q.size() > 0 && (sb_q[0].when <= cyc || done)) begin
      exp_t e;
      int   act;
      e = sb_q.pop_front();
      n_cmp++;
      if (e.when != cyc) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d not taken (now %0d)", e.tag, e.when, cyc);
      end else if (e.kind == 0) begin
        if ((gate & e.mask) !== e.val) begin
          n_err++;
          $display("FAIL %s: cycle %0d gate&%h = %h, expected %h", e.tag, cyc, e.mask, gate & e.mask, e.val);
        end
      end else begin
        act = (e.kind == 1) ? int'(chg_cnt - e.base) : int'(h2a_hi_cnt - e.base);
        if (act < e.lo || act > e.hi) begin
          n_err++;
          $display("FAIL %s: got %0d, expected %0d..%0d", e.tag, act, e.lo, e.hi);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_gate(input int unsigned off, input logic [7:0] val, input logic [7:0] mask, input string tag);
    exp_t e;
    e.when = cyc + off; e.kind = 0; e.val = val & mask; e.mask = mask;
    e.base = 0; e.lo = 0; e.hi = 0; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_cnt(input int kind, input int unsigned base, input int lo, input int hi, input string tag);
    exp_t e;
    e.when = cyc; e.kind = kind; e.val = 8'h00; e.mask = 8'h00;
    e.base = base; e.lo = lo; e.hi = hi; e.tag = tag;
    sb_q.push_back(e);
  endtask

  initial begin
    int unsigned base_chg;
    int unsigned base_hi;
    int          q;
    int          c2;

    rst_n = 1'b0; enable = 1'b1; ref_in = 16'sd0; carrier1 = -16'sd100; carrier2 = 16'sd100;
    sync_pulse = 1'b0; deadtime = 8'd10;
    tick(3);
    push_gate(0, 8'h00, 8'hFF, "reset_gate");
    tick(1);

    // ref 0, dt 10: all lo after reset, H1 legs go through DEAD to hi, then steady
    rst_n = 1'b1;
    push_gate(1,  8'h55, 8'hFF, "reset_exit_lo");
    push_gate(2,  8'h50, 8'hFF, "h1_dead_start");
    push_gate(11, 8'h50, 8'hFF, "h1_dead_end");
    push_gate(12, 8'h5A, 8'hFF, "h1_hi_on");
    for (int j = 1; j <= 7; j++) push_gate(12 + 20 * j, 8'h5A, 8'hFF, "ref0_steady");
    for (int j = 0; j < 8; j++) begin
      tick(20);
      sync_pulse = 1'b1;
      tick(1);
      sync_pulse = 1'b0;
    end
    tick(2);

    // Single step, dt 20: hi falls 1 cycle after compare, lo 20 cycles later
    deadtime = 8'd20; carrier1 = 16'sd0;
    push_gate(1,  8'h5A, 8'hFF, "step_before");
    push_gate(2,  8'h50, 8'hFF, "step_hi_off");
    push_gate(21, 8'h50, 8'hFF, "step_dead_last");
    push_gate(22, 8'h55, 8'hFF, "step_lo_on");
    tick(25);

    // dt 0: one-cycle gap both directions
    deadtime = 8'd0; carrier1 = -16'sd100;
    push_gate(1, 8'h55, 8'hFF, "dt0_rise_before");
    push_gate(2, 8'h50, 8'hFF, "dt0_rise_gap");
    push_gate(3, 8'h5A, 8'hFF, "dt0_rise_hi");
    tick(5);
    carrier1 = 16'sd0;
    push_gate(1, 8'h5A, 8'hFF, "dt0_fall_before");
    push_gate(2, 8'h50, 8'hFF, "dt0_fall_gap");
    push_gate(3, 8'h55, 8'hFF, "dt0_fall_lo");
    tick(5);

    // dt 50 with two command toggles inside the dead interval
    deadtime = 8'd50; carrier1 = -16'sd100;
    push_gate(1,  8'h55, 8'hFF, "tog_before");
    push_gate(2,  8'h50, 8'hFF, "tog_dead");
    push_gate(30, 8'h50, 8'hFF, "tog_dead_mid");
    push_gate(51, 8'h50, 8'hFF, "tog_dead_last");
    push_gate(52, 8'h5A, 8'hFF, "tog_expiry_hi");
    tick(10);
    carrier1 = 16'sd0;
    tick(10);
    carrier1 = -16'sd100;
    tick(35);

    // ref -32768: neg_ref saturates to +32767 and beats carrier2 = 32766
    deadtime = 8'd2; carrier2 = 16'sd32766; ref_in = -16'sd32768; sync_pulse = 1'b1;
    push_gate(2, 8'h5A, 8'hFF, "sat_before");
    push_gate(3, 8'h18, 8'hFF, "sat_dead");
    push_gate(4, 8'h18, 8'hFF, "sat_dead2");
    push_gate(5, 8'h99, 8'hFF, "sat_neg_ref");
    tick(1);
    sync_pulse = 1'b0;
    tick(6);

    // Enable drop with hi sides on, inputs moved while disabled, then re-enable with dt 3
    enable = 1'b0;
    push_gate(1, 8'h00, 8'hFF, "disable_next_edge");
    push_gate(4, 8'h00, 8'hFF, "disable_hold");
    tick(1);
    ref_in = 16'sd0; carrier1 = -16'sd100; carrier2 = 16'sd100; deadtime = 8'd3; sync_pulse = 1'b1;
    tick(4);
    sync_pulse = 1'b0; enable = 1'b1;
    push_gate(2, 8'h00, 8'hFF, "reenable_dead");
    push_gate(3, 8'h5A, 8'hFF, "reenable_on");
    tick(5);

    // Reset asserted mid-dead clears gates without waiting for an edge
    deadtime = 8'd30; carrier1 = 16'sd0;
    push_gate(2, 8'h50, 8'hFF, "rst_mid_dead_pre");
    tick(10);
    rst_n = 1'b0;
    push_gate(0, 8'h00, 8'hFF, "rst_mid_dead_async");
    tick(2);
    rst_n = 1'b1;
    push_gate(1, 8'h55, 8'hFF, "rst2_exit_lo");
    push_gate(5, 8'h55, 8'hFF, "rst2_steady");
    tick(8);

    // ref +16384 against 5 kHz level-shifted triangles (20000-cycle period)
    deadtime = 8'd10; carrier2 = 16'sd0; carrier1 = -16'sd32768; ref_in = 16'sd16384; sync_pulse = 1'b1;
    tick(1);
    sync_pulse = 1'b0;
    tick(40);
    push_gate(0, 8'h6A, 8'hFF, "pwm_settled");
    tick(1);
    base_chg = chg_cnt;
    base_hi  = h2a_hi_cnt;
    for (int p = 0; p < 40000; p++) begin
      q  = p % 20000;
      c2 = (q < 10000) ? (q * 32767) / 10000 : ((20000 - q) * 32767) / 10000;
      carrier2   = 16'(c2);
      carrier1   = 16'(c2 - 32768);
      sync_pulse = (q == 10000);
      if (q == 2500 || q == 17500) push_gate(0, 8'h6A, 8'hFF, "pwm_low_carrier");
      else if (q == 7500 || q == 12500) push_gate(0, 8'h56, 8'hFF, "pwm_high_carrier");
      tick(1);
    end
    sync_pulse = 1'b0;
    tick(20);
    push_cnt(1, base_chg, 8, 8, "pwm_gate_changes");
    push_cnt(2, base_hi, 19800, 20200, "pwm_h2a_duty");
    tick(2);

    done = 1'b1;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 SHALL have parameter CARRIER_WIDTH, default 16, giving the signed width of the reference and carrier inputs.
REQ-002 SHALL have parameter DT_WIDTH, default 8, giving the dead-time count width.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  gate-drive enable; low forces all gates off.
REQ-006 SHALL have port ref_in  input  CARRIER_WIDTH signed  modulation reference sample.
REQ-007 SHALL have port carrier1  input  CARRIER_WIDTH signed  lower carrier, -32768..0.
REQ-008 SHALL have port carrier2  input  CARRIER_WIDTH signed  upper carrier, 0..+32767.
REQ-009 SHALL have port sync_pulse  input  1  one-cycle strobe at carrier peak.
REQ-010 SHALL have port deadtime  input  DT_WIDTH  dead time in clk cycles.
REQ-011 SHALL have port gate  output  8  switch gates [1:0]=H1 legA hi/lo, [3:2]=H1 legB, [5:4]=H2 legA, [7:6]=H2 legB; bit 1 = on.

Function
REQ-012 SHALL hold a shadow reference ref_sh, loaded from ref_in in any cycle where sync_pulse=1 or enable=0, and held otherwise.
REQ-013 SHALL form neg_ref = -ref_sh, saturated so that -(-32768) gives +32767.
REQ-014 SHALL register four leg commands each cycle (1-cycle latency): H1A = ref_sh > carrier1, H1B = neg_ref > carrier1, H2A = ref_sh > carrier2, H2B = neg_ref > carrier2, all as signed strict compares.
REQ-015 SHALL drive each leg through a 3-state FSM: HI_ON (hi=1, lo=0), LO_ON (hi=0, lo=1), DEAD (hi=0, lo=0).
REQ-016 SHALL exit reset and leave disable in DEAD with target LO, and SHALL never assert hi and lo of one leg simultaneously.
REQ-017 SHALL, in HI_ON or LO_ON, move to DEAD on the first cycle the command differs from the active side, and SHALL load the dead counter with max(deadtime,1) sampled at that cycle.
REQ-018 SHALL decrement the dead counter in DEAD and, on the cycle it reaches 0, enter HI_ON if the current command = 1, else LO_ON.
REQ-019 SHALL NOT restart the dead counter if the command toggles during DEAD; the side entered is decided only at expiry.
REQ-020 SHALL give the total delay from carrier crossing to the new side asserting as 1 (compare) + max(deadtime,1) cycles.
REQ-021 SHALL, when enable falls, force all gate bits to 0 on the next edge and put every leg in DEAD with counter max(deadtime,1), so that lo-side turn-on after re-enable respects dead time.
REQ-022 SHALL, with enable low, keep gate = 8'h00 regardless of the other inputs.

Reset
REQ-023 SHALL, while rst_n=0, set gate=8'h00, ref_sh=0, all leg commands 0, all FSMs DEAD and dead counters 0.
REQ-024 SHALL, at the first enabled cycles after reset, enter LO_ON once the counter expiry of REQ-018 completes (counter 0 means expiry on the first enabled cycle).
REQ-025 SHALL abort any dead interval on reset assertion mid-operation with no glitch beyond the asynchronous clear.

Structure
REQ-026 SHALL place the leg FSM state encoding and the gate bit-index constants in the shared inverter package.
REQ-027 SHALL implement one sub-module deadtime_leg (cmd in, hi/lo out, deadtime in, enable in), instantiated four times.

Verification
REQ-028 SHALL verify: ref_in=0 with sync pulses and deadtime=10 -> H1 legA/legB steady hi, H2 legA/legB steady lo, no transitions after settling.
REQ-029 SHALL verify: ref_in=+16384 latched on sync_pulse, 5 kHz carriers -> H1B and H2A each toggle once per carrier half-period with about 50% duty, and H1A stays hi.
REQ-030 SHALL verify: a single command step with deadtime=20 -> hi falls 1 cycle after the carrier crossing and lo rises exactly 20 cycles later.
REQ-031 SHALL verify: deadtime=0 -> a 1-cycle both-off gap at every transition.
REQ-032 SHALL verify: the command toggles twice within a 50-cycle dead interval -> one DEAD interval, after which the side matching the command at expiry asserts.
REQ-033 SHALL verify: ref_in=-32768 -> neg_ref=+32767 with no wrap; enable dropped mid-pulse -> gate=00 on the next edge; rst_n low mid-dead -> immediate gate=00; and an assertion holds that hi&lo=0 on every leg in every cycle.
